// File: rtl/nor_bist_if.sv
// -----------------------------------------------------------------------------
// nor_bist_if
// Bundles the sweep controls and the gate-under-test connection of the NOR
// built-in self-test controller.
//
//   start    : request one test sweep (driven by master)
//   abort    : terminate a sweep in progress (driven by master)
//   dut_out  : output of the gate under test (driven by master side / gate)
//   dut_a    : input A applied to the gate under test (driven by slave)
//   dut_b    : input B applied to the gate under test (driven by slave)
//   busy     : sweep in progress (driven by slave)
//   done     : one-cycle completion pulse (driven by slave)
//   pass     : result of the last completed sweep (driven by slave)
//   fail_vec : per-vector mismatch flags, bit k = vector {a,b}=k (driven by slave)
//
// Modports: master = test sequencer / environment, slave = nor_bist_ctrl.
// -----------------------------------------------------------------------------
interface nor_bist_if;
   logic       start;
   logic       abort;
   logic       dut_out;
   logic       dut_a;
   logic       dut_b;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] fail_vec;

   modport master (
      output start, abort, dut_out,
      input  dut_a, dut_b, busy, done, pass, fail_vec
   );

   modport slave (
      input  start, abort, dut_out,
      output dut_a, dut_b, busy, done, pass, fail_vec
   );
endinterface

// File: rtl/nor_bist_ctrl.sv
// -----------------------------------------------------------------------------
// nor_bist_ctrl
// Exhaustive functional test of a 2-input gate. On an accepted start the four
// input vectors {a,b} = 0,1,2,3 are applied in order, each held for SETTLE
// cycles; dut_out is compared (case-equality) against TRUTH[{a,b}] in the last
// cycle of each window. Mismatches are flagged per vector in fail_vec and the
// overall result is reported on pass together with a one-cycle done pulse.
//
// Parameters:
//   SETTLE : cycles each vector is held before sampling (1..255, 0 acts as 1)
//   TRUTH  : expected gate output indexed by {a,b} (default 4'b0001 = NOR)
//
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : nor_bist_if.slave (start/abort/dut_out in, vectors/status out)
// -----------------------------------------------------------------------------
module nor_bist_ctrl #(
   parameter int unsigned SETTLE = 4,
   parameter logic [3:0]  TRUTH  = 4'b0001
) (
   input logic          clk,
   input logic          rst_n,
   nor_bist_if.slave    bus
);

   // A settle of zero would leave no sampling cycle; treat it as one.
   localparam int unsigned S_EFF = (SETTLE == 0) ? 1 : SETTLE;
   localparam logic [7:0]  LAST  = 8'(S_EFF - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state,    state_d;
   logic [1:0] vec,      vec_d;
   logic [7:0] cnt,      cnt_d;
   logic       dut_a_q,  dut_a_d;
   logic       dut_b_q,  dut_b_d;
   logic [3:0] fail_q,   fail_d;
   logic       pass_q,   pass_d;
   logic       mismatch;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values computed by the combinational process.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         vec     <= 2'd0;
         cnt     <= 8'd0;
         dut_a_q <= 1'b0;
         dut_b_q <= 1'b0;
         fail_q  <= 4'b0000;
         pass_q  <= 1'b0;
      end else begin
         state   <= state_d;
         vec     <= vec_d;
         cnt     <= cnt_d;
         dut_a_q <= dut_a_d;
         dut_b_q <= dut_b_d;
         fail_q  <= fail_d;
         pass_q  <= pass_d;
      end
   end

   // NOTE: every signal assigned here gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      state_d  = state;
      vec_d    = vec;
      cnt_d    = cnt;
      dut_a_d  = dut_a_q;
      dut_b_d  = dut_b_q;
      fail_d   = fail_q;
      pass_d   = pass_q;
      mismatch = 1'b0;

      case (state)
         IDLE: begin
            // abort beats start; the vector registers are already 0 here.
            if (bus.start && !bus.abort) begin
               state_d = RUN;
               vec_d   = 2'd0;
               cnt_d   = 8'd0;
               dut_a_d = 1'b0;
               dut_b_d = 1'b0;
               fail_d  = 4'b0000;
               pass_d  = 1'b0;
            end
         end

         RUN: begin
            if (bus.abort) begin
               // Abort takes priority over a sample in the same cycle; flags
               // of vectors already sampled are kept, pass stays cleared.
               state_d = IDLE;
               vec_d   = 2'd0;
               cnt_d   = 8'd0;
               dut_a_d = 1'b0;
               dut_b_d = 1'b0;
            end else if (cnt == LAST) begin
               // Case-inequality so X/Z on the gate output counts as a failure.
               mismatch     = (bus.dut_out !== TRUTH[vec]);
               fail_d[vec]  = fail_q[vec] | mismatch;
               cnt_d        = 8'd0;
               if (vec == 2'd3) begin
                  // Last vector: index stays at 3, gate inputs return to 0.
                  state_d = DONE;
                  dut_a_d = 1'b0;
                  dut_b_d = 1'b0;
                  pass_d  = (fail_d == 4'b0000);
               end else begin
                  vec_d   = vec + 2'd1;
                  dut_a_d = vec_d[1];
                  dut_b_d = vec_d[0];
               end
            end else begin
               cnt_d = cnt + 8'd1;
            end
         end

         DONE: begin
            state_d = IDLE;
            vec_d   = 2'd0;
            cnt_d   = 8'd0;
         end

         default: begin
            state_d = IDLE;
            vec_d   = 2'd0;
            cnt_d   = 8'd0;
            dut_a_d = 1'b0;
            dut_b_d = 1'b0;
         end
      endcase
   end

   assign bus.dut_a    = dut_a_q;
   assign bus.dut_b    = dut_b_q;
   assign bus.busy     = (state == RUN);
   assign bus.done     = (state == DONE);
   assign bus.pass     = pass_q;
   assign bus.fail_vec = fail_q;

endmodule

// File: tb/tb_nor_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nor_bist_ctrl
// Three controllers run side by side from shared start/abort controls:
//   inst 0 : SETTLE=4, TRUTH=NOR
//   inst 1 : SETTLE=1, TRUTH=NOR
//   inst 2 : SETTLE=0 (acts as 1), TRUTH=XOR (4'b0110)
// Each has its own gate model on dut_out. The reference model tracks, per
// instance, the number of cycles elapsed since a sweep was accepted and derives
// every expected output from that count with plain arithmetic.
// Observed word per instance: {dut_a, dut_b, busy, done, pass, fail_vec[3:0]}.
// -----------------------------------------------------------------------------
module tb_nor_bist_ctrl;

   localparam int         NI = 3;
   localparam int         SEFF   [NI] = '{4, 1, 1};
   localparam logic [3:0] TRUTHS [NI] = '{4'b0001, 4'b0001, 4'b0110};

   localparam logic [2:0] M_IDEAL = 3'd0;
   localparam logic [2:0] M_ONE   = 3'd1;
   localparam logic [2:0] M_ZERO  = 3'd2;
   localparam logic [2:0] M_UNK   = 3'd3;
   localparam logic [2:0] M_RAND  = 3'd4;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [2:0] mode  = M_IDEAL;
   logic       rnd   = 1'b0;
   logic       dout [NI];
   logic [8:0] obs  [NI];

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;

   // Reference model state: t = 0 idle, 1..4S running, 4S+1 done cycle.
   int         mt     [NI];
   logic [3:0] mflags [NI];
   logic       mpass  [NI];

   nor_bist_if bus4 ();
   nor_bist_if bus1 ();
   nor_bist_if bus0 ();

   nor_bist_ctrl #(.SETTLE(4)) u_s4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
   nor_bist_ctrl #(.SETTLE(1)) u_s1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
   nor_bist_ctrl #(.SETTLE(0), .TRUTH(4'b0110)) u_s0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));

   assign bus4.start = start;  assign bus4.abort = abort;  assign bus4.dut_out = dout[0];
   assign bus1.start = start;  assign bus1.abort = abort;  assign bus1.dut_out = dout[1];
   assign bus0.start = start;  assign bus0.abort = abort;  assign bus0.dut_out = dout[2];

   assign obs[0] = {bus4.dut_a, bus4.dut_b, bus4.busy, bus4.done, bus4.pass, bus4.fail_vec};
   assign obs[1] = {bus1.dut_a, bus1.dut_b, bus1.busy, bus1.done, bus1.pass, bus1.fail_vec};
   assign obs[2] = {bus0.dut_a, bus0.dut_b, bus0.busy, bus0.done, bus0.pass, bus0.fail_vec};

   always #5 clk = ~clk;

   // Gate models feeding dut_out of each controller.
   always_comb begin
      for (int i = 0; i < NI; i++) begin
         dout[i] = 1'b0;
         case (mode)
            M_IDEAL: dout[i] = TRUTHS[i][{obs[i][8], obs[i][7]}];
            M_ONE:   dout[i] = 1'b1;
            M_ZERO:  dout[i] = 1'b0;
            M_UNK:   dout[i] = 1'bx;
            M_RAND:  dout[i] = rnd;
            default: dout[i] = 1'b0;
         endcase
      end
   end

   // Reference model: advances on each rising edge using pre-edge inputs.
   always @(posedge clk or negedge rst_n) begin : ref_model
      int         t, s, k;
      logic [3:0] f;
      logic       p;
      if (!rst_n) begin
         for (int i = 0; i < NI; i++) begin
            mt[i]     <= 0;
            mflags[i] <= 4'b0000;
            mpass[i]  <= 1'b0;
         end
      end else begin
         for (int i = 0; i < NI; i++) begin
            t = mt[i];
            s = SEFF[i];
            f = mflags[i];
            p = mpass[i];
            if (t == 0) begin
               if (start && !abort) begin
                  t = 1;
                  f = 4'b0000;
                  p = 1'b0;
               end
            end else if (t == 4 * s + 1) begin
               t = 0;
            end else if (abort) begin
               t = 0;
            end else begin
               if (t % s == 0) begin
                  k = t / s - 1;
                  if (dout[i] !== TRUTHS[i][k]) f[k] = 1'b1;
               end
               if (t == 4 * s) p = (f == 4'b0000);
               t = t + 1;
            end
            mt[i]     <= t;
            mflags[i] <= f;
            mpass[i]  <= p;
         end
      end
   end

   function automatic logic [8:0] expv(input int i);
      int t, s, k;
      t = mt[i];
      s = SEFF[i];
      if (t >= 1 && t <= 4 * s) begin
         k = (t - 1) / s;
         return {k[1], k[0], 1'b1, 1'b0, mpass[i], mflags[i]};
      end else if (t == 4 * s + 1) begin
         return {2'b00, 1'b0, 1'b1, mpass[i], mflags[i]};
      end
      return {2'b00, 1'b0, 1'b0, mpass[i], mflags[i]};
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (obs[i] !== 9'h000) begin
            fails++;
            $display("FAIL reset_async inst%0d: got %b expected %b", i, obs[i], 9'h000);
         end
      end
      step();
      step();
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (obs[i] !== 9'h000) begin
            fails++;
            $display("FAIL reset_held inst%0d: got %b expected %b", i, obs[i], 9'h000);
         end
      end
      rst_n = 1'b1;
      for (int n = 0; n < 3; n++) begin
         step();
         for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs[i] !== expv(i)) begin
               fails++;
               $display("FAIL reset_idle inst%0d cycle %0d: got %b expected %b", i, cyc, obs[i], expv(i));
            end
         end
      end
   endtask

   task automatic test_ideal();
      mode  = M_IDEAL;
      start = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         step();
         if (n == 1) start = 1'b0;
         for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs[i] !== expv(i)) begin
               fails++;
               $display("FAIL ideal inst%0d cycle T+%0d: got %b expected %b", i, n, obs[i], expv(i));
            end
         end
         if (n == 17) begin
            checks++;
            if (obs[0] !== 9'b000110000) begin
               fails++;
               $display("FAIL ideal_done_s4: got %b expected %b", obs[0], 9'b000110000);
            end
         end
         if (n == 5) begin
            checks++;
            if (obs[2] !== 9'b000110000) begin
               fails++;
               $display("FAIL ideal_done_xor: got %b expected %b", obs[2], 9'b000110000);
            end
         end
      end
   endtask

   task automatic test_stuck(input logic [2:0] m, input logic [8:0] done_word);
      mode  = m;
      start = 1'b1;
      for (int n = 1; n <= 19; n++) begin
         step();
         if (n == 1) start = 1'b0;
         for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs[i] !== expv(i)) begin
               fails++;
               $display("FAIL stuck%0d inst%0d cycle T+%0d: got %b expected %b", m, i, n, obs[i], expv(i));
            end
         end
         if (n == 17) begin
            checks++;
            if (obs[0] !== done_word) begin
               fails++;
               $display("FAIL stuck%0d_done_s4: got %b expected %b", m, obs[0], done_word);
            end
         end
      end
   endtask

   task automatic test_unknown();
      mode  = M_UNK;
      start = 1'b1;
      for (int n = 1; n <= 19; n++) begin
         step();
         if (n == 1) start = 1'b0;
         for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs[i] !== expv(i)) begin
               fails++;
               $display("FAIL unknown inst%0d cycle T+%0d: got %b expected %b", i, n, obs[i], expv(i));
            end
         end
         if (n == 5) begin
            checks++;
            if (obs[1][5] !== 1'b1) begin
               fails++;
               $display("FAIL unknown_done_s1: got done=%b expected 1", obs[1][5]);
            end
         end
      end
   endtask

   task automatic test_abort();
      mode  = M_ONE;
      start = 1'b1;
      for (int n = 1; n <= 24; n++) begin
         step();
         if (n == 1) start = 1'b0;
         for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs[i] !== expv(i)) begin
               fails++;
               $display("FAIL abort inst%0d cycle T+%0d: got %b expected %b", i, n, obs[i], expv(i));
            end
         end
         if (n == 7) begin
            checks++;
            if (obs[0] !== 9'b000000000) begin
               fails++;
               $display("FAIL abort_idle_s4: got %b expected %b", obs[0], 9'b000000000);
            end
         end
         if (n >= 7) begin
            checks++;
            if (obs[0][5] !== 1'b0) begin
               fails++;
               $display("FAIL abort_no_done cycle T+%0d: got done=%b expected 0", n, obs[0][5]);
            end
         end
         abort = (n == 6);
      end
   endtask

   task automatic test_back_to_back();
      mode  = M_IDEAL;
      start = 1'b1;
      for (int n = 1; n <= 38; n++) begin
         step();
         if (n == 19) start = 1'b0;
         for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs[i] !== expv(i)) begin
               fails++;
               $display("FAIL back_to_back inst%0d cycle T+%0d: got %b expected %b", i, n, obs[i], expv(i));
            end
         end
         if (n == 18 || n == 19) begin
            checks++;
            if (obs[0][6] !== (n == 19)) begin
               fails++;
               $display("FAIL b2b_restart_s4 cycle T+%0d: got busy=%b expected %b", n, obs[0][6], (n == 19));
            end
         end
         if (n == 35) begin
            checks++;
            if (obs[0] !== 9'b000110000) begin
               fails++;
               $display("FAIL b2b_second_done_s4: got %b expected %b", obs[0], 9'b000110000);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      mode  = M_ONE;
      start = 1'b1;
      for (int n = 1; n <= 9; n++) begin
         step();
         if (n == 1) start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (obs[i] !== 9'h000) begin
            fails++;
            $display("FAIL reset_mid_async inst%0d: got %b expected %b", i, obs[i], 9'h000);
         end
      end
      step();
      step();
      rst_n = 1'b1;
      mode  = M_IDEAL;
      for (int n = 0; n < 3; n++) begin
         step();
         checks++;
         if (obs[0] !== 9'h000) begin
            fails++;
            $display("FAIL reset_mid_idle cycle %0d: got %b expected %b", cyc, obs[0], 9'h000);
         end
      end
      start = 1'b1;
      for (int n = 1; n <= 19; n++) begin
         step();
         if (n == 1) start = 1'b0;
         for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs[i] !== expv(i)) begin
               fails++;
               $display("FAIL reset_mid_rerun inst%0d cycle T+%0d: got %b expected %b", i, n, obs[i], expv(i));
            end
         end
         if (n == 17) begin
            checks++;
            if (obs[0] !== 9'b000110000) begin
               fails++;
               $display("FAIL reset_mid_done_s4: got %b expected %b", obs[0], 9'b000110000);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         step();
         for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs[i] !== expv(i)) begin
               fails++;
               $display("FAIL random inst%0d cycle %0d: got %b expected %b", i, cyc, obs[i], expv(i));
            end
         end
         if ($urandom_range(0, 19) == 0) mode = 3'($urandom_range(0, 4));
         start = ($urandom_range(0, 2) == 0);
         abort = ($urandom_range(0, 23) == 0);
         rnd   = 1'($urandom_range(0, 1));
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   initial begin
      test_reset();
      test_ideal();
      test_stuck(M_ONE,  9'b000101110);
      test_stuck(M_ZERO, 9'b000100001);
      test_unknown();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
